xor_arbiter: RTL and testbench

Round-robin scheduler that shares a single N-bit bitwise-XOR datapath among four requesters. Each requester presents an operand pair and holds it until acknowledged. The arbiter grants one requester per cycle, computes `a ^ b` through one shared XOR instance, and registers the result together with the requester's tag. A valid/ready output port lets the downstream consumer apply backpressure. It sits between the per-channel operand sources and the result sink.

---
 rtl/xor_arbiter.sv | 110 +++++++++++
 tb/tb_xor_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/xor_arbiter.sv
// xor_arbiter: four requesters share one N-bit XOR datapath under
// round-robin arbitration. The result and the winner's tag are registered
// behind a valid/ready output port.
module xor_arbiter #(
   parameter int N = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [3:0]     req,
   input  logic [4*N-1:0] a_in,
   input  logic [4*N-1:0] b_in,
   output logic [3:0]     ack,
   output logic [N-1:0]   f_out,
   output logic [1:0]     f_tag,
   output logic           f_valid,
   input  logic           f_ready
);

   logic [1:0]   ptr_q,     ptr_d;
   logic [N-1:0] f_out_q,   f_out_d;
   logic [1:0]   f_tag_q,   f_tag_d;
   logic         f_valid_q, f_valid_d;

   logic [N-1:0] a_arr [4];
   logic [N-1:0] b_arr [4];
   logic [7:0]   req_dbl;
   logic [3:0]   req_rot;
   logic [1:0]   grant_off;
   logic [1:0]   grant_idx;
   logic         out_free;
   logic         grant_valid;
   logic [N-1:0] xor_res;

   // Unpack the per-requester operand slices.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
         assign a_arr[gi] = a_in[gi*N +: N];
         assign b_arr[gi] = b_in[gi*N +: N];
      end
   endgenerate

   // Rotate the request vector so that bit 0 is the requester at ptr.
   assign req_dbl = {req, req};
   assign req_rot = req_dbl[ptr_q +: 4];

   // Priority-encode the rotated requests; the lowest offset from ptr wins.
   always_comb begin
      grant_off = 2'd0;
      casez (req_rot)
         4'b???1: grant_off = 2'd0;
         4'b??10: grant_off = 2'd1;
         4'b?100: grant_off = 2'd2;
         4'b1000: grant_off = 2'd3;
         default: grant_off = 2'd0;
      endcase
   end

   // The output register may take a new result when it is empty or being drained.
   assign out_free    = !f_valid_q || f_ready;
   assign grant_valid = !rst && out_free && (req != 4'b0000);
   // Two-bit addition wraps 3 back to 0.
   assign grant_idx   = ptr_q + grant_off;

   // The single shared XOR, fed from the granted requester's operands.
   assign xor_res = a_arr[grant_idx] ^ b_arr[grant_idx];

   // One-hot acknowledge for the winner; depends only on control inputs.
   always_comb begin
      ack = 4'b0000;
      if (grant_valid) begin
         ack = 4'b0001 << grant_idx;
      end
   end

   // Next-state: load on grant, drop valid on a drain with no grant, else hold.
   always_comb begin
      ptr_d     = ptr_q;
      f_out_d   = f_out_q;
      f_tag_d   = f_tag_q;
      f_valid_d = f_valid_q;
      if (grant_valid) begin
         f_out_d   = xor_res;
         f_tag_d   = grant_idx;
         f_valid_d = 1'b1;
         ptr_d     = grant_idx + 2'd1;
      end else if (f_valid_q && f_ready) begin
         f_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q     <= 2'd0;
         f_out_q   <= '0;
         f_tag_q   <= 2'd0;
         f_valid_q <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         f_out_q   <= f_out_d;
         f_tag_q   <= f_tag_d;
         f_valid_q <= f_valid_d;
      end
   end

   assign f_out   = f_out_q;
   assign f_tag   = f_tag_q;
   assign f_valid = f_valid_q;

endmodule

// File: tb/tb_xor_arbiter.sv
// Scoreboard bench for xor_arbiter: the stimulus process checks grants and
// queues the expected {tag, result}; a monitor pops and compares each result
// as it is consumed on the output port.
module tb_xor_arbiter;

   localparam int N = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic [3:0]     req;
   logic [4*N-1:0] a_in;
   logic [4*N-1:0] b_in;
   logic [3:0]     ack;
   logic [N-1:0]   f_out;
   logic [1:0]     f_tag;
   logic           f_valid;
   logic           f_ready;

   int errors = 0;
   int checks = 0;

   logic [17:0] sb_q [$];

   // Hand-computed a ^ b for each requester's fixed operands.
   logic [N-1:0] exp_res [4];

   xor_arbiter #(.N(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .a_in    (a_in),
      .b_in    (b_in),
      .ack     (ack),
      .f_out   (f_out),
      .f_tag   (f_tag),
      .f_valid (f_valid),
      .f_ready (f_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end else begin
         $display("ok   %s: %h (t=%0t)", name, act, $time);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Check the grant for the current inputs; queue the expected result if granted.
   task automatic expect_grant(input string name, input logic [3:0] exp_ack);
      #1;
      chk(name, {28'd0, ack}, {28'd0, exp_ack});
      for (int i = 0; i < 4; i++) begin
         if (exp_ack[i]) sb_q.push_back({i[1:0], exp_res[i]});
      end
   endtask

   // Monitor: every consumed result must match the head of the scoreboard.
   initial begin
      logic [17:0] e;
      forever begin
         @(negedge clk);
         if (f_valid === 1'b1 && f_ready === 1'b1 && rst === 1'b0) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_result", {14'd0, f_tag, f_out}, 32'hFFFF_FFFF);
            end else begin
               e = sb_q.pop_front();
               chk("result_tag", {30'd0, f_tag}, {30'd0, e[17:16]});
               chk("result_data", {16'd0, f_out}, {16'd0, e[15:0]});
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      exp_res[0] = 16'h12CB;  // 1234 ^ 00FF
      exp_res[1] = 16'hF0F0;  // FFFF ^ 0F0F
      exp_res[2] = 16'hAA55;  // A5A5 ^ 0FF0
      exp_res[3] = 16'h8000;  // 8001 ^ 0001
      a_in    = {16'h8001, 16'hA5A5, 16'hFFFF, 16'h1234};
      b_in    = {16'h0001, 16'h0FF0, 16'h0F0F, 16'h00FF};
      rst     = 1'b1;
      req     = 4'b1111;
      f_ready = 1'b1;

      // Reset with every requester asking.
      cycle();
      cycle();
      chk("reset_ack", {28'd0, ack}, 32'd0);
      chk("reset_valid", {31'd0, f_valid}, 32'd0);
      chk("reset_out", {16'd0, f_out}, 32'd0);
      chk("reset_tag", {30'd0, f_tag}, 32'd0);

      // Round robin with wrap: 0,1,2,3,0.
      rst = 1'b0;
      expect_grant("rr_grant0", 4'b0001);
      cycle(); expect_grant("rr_grant1", 4'b0010);
      cycle(); expect_grant("rr_grant2", 4'b0100);
      cycle(); expect_grant("rr_grant3", 4'b1000);
      cycle(); expect_grant("rr_grant0_wrap", 4'b0001);
      cycle(); req = 4'b0000;
      expect_grant("rr_idle_ack", 4'b0000);

      // Single request from requester 2 (ptr is 1 here).
      cycle(); req = 4'b0100;
      expect_grant("single_ack", 4'b0100);
      cycle(); req = 4'b0000;
      chk("single_valid", {31'd0, f_valid}, 32'd1);
      chk("single_out", {16'd0, f_out}, 32'h0000_AA55);
      chk("single_tag", {30'd0, f_tag}, 32'd2);

      // Idle with f_ready high: valid falls, ptr stays at 3.
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("idle_valid_low", {31'd0, f_valid}, 32'd0);
      end
      cycle(); req = 4'b1111;
      expect_grant("idle_ptr_kept", 4'b1000);

      // Build a tag-1 result with ptr landing on 2.
      cycle(); req = 4'b0010;
      expect_grant("bp_setup", 4'b0010);

      // Stall: requester 1 asks in the first stalled cycle, then withdraws.
      for (int k = 0; k < 3; k++) begin
         cycle();
         f_ready = 1'b0;
         req = (k == 0) ? 4'b1011 : 4'b1001;
         expect_grant("bp_stall_ack", 4'b0000);
         chk("bp_hold_tag", {30'd0, f_tag}, 32'd1);
         chk("bp_hold_out", {16'd0, f_out}, 32'h0000_F0F0);
      end
      cycle(); f_ready = 1'b1; req = 4'b1001;
      expect_grant("bp_release", 4'b1000);
      cycle(); req = 4'b0100;
      expect_grant("pre_reset_grant", 4'b0100);

      // Stall the tag-2 result, then reset it away.
      cycle(); req = 4'b0000; f_ready = 1'b0;
      chk("mid_valid", {31'd0, f_valid}, 32'd1);
      chk("mid_tag", {30'd0, f_tag}, 32'd2);
      if (sb_q.size() != 0) void'(sb_q.pop_back());
      cycle(); rst = 1'b1; req = 4'b1111;
      expect_grant("mid_reset_ack", 4'b0000);
      cycle();
      chk("mid_reset_valid", {31'd0, f_valid}, 32'd0);
      chk("mid_reset_out", {16'd0, f_out}, 32'd0);
      rst = 1'b0; req = 4'b1010; f_ready = 1'b1;
      expect_grant("post_reset_grant", 4'b0010);
      cycle(); req = 4'b0000;
      cycle();
      cycle();
      chk("scoreboard_empty", sb_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
